// File: rtl/audio_pkg.sv
// Shared audio-path definitions: I2S frame geometry, transmitter states and the
// WM8731 constants also used by the codec configuration block.
package audio_pkg;

  localparam int unsigned SAMPLE_W  = 24;
  localparam int unsigned SLOTS     = 32;
  localparam int unsigned I2S_DELAY = 1;

  // WM8731 framing shared with the I2C configuration block
  localparam int unsigned MCLK_PER_FS     = 256;
  localparam int unsigned FRAME_SLOTS     = 2 * SLOTS;
  localparam logic [6:0]  WM8731_I2C_ADDR = 7'h1A;
  localparam int unsigned WM8731_CMD_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } tx_state_e;

endpackage

// File: rtl/i2s_clk_gen.sv
// BCLK divider and slot counter; strobes mark the clk cycle before each BCLK edge.
module i2s_clk_gen #(
  parameter int unsigned BCLK_DIV = 4,
  parameter int unsigned SLOTS    = audio_pkg::SLOTS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  output logic                         fall_c,
  output logic                         rise_c,
  output logic                         frame_start_c,
  output logic [$clog2(2*SLOTS)-1:0]   slot
);

  localparam int unsigned DIV_W  = $clog2(BCLK_DIV);
  localparam int unsigned SLOT_W = $clog2(2*SLOTS);

  logic [DIV_W-1:0] div_cnt;

  // slot holds the index opened by the next fall strobe
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      div_cnt <= '0;
      slot    <= '0;
    end else begin
      div_cnt <= (div_cnt == DIV_W'(BCLK_DIV-1)) ? '0 : div_cnt + DIV_W'(1);
      if (fall_c)
        slot <= (slot == SLOT_W'(2*SLOTS-1)) ? '0 : slot + SLOT_W'(1);
    end
  end

  assign fall_c        = en && (div_cnt == DIV_W'(BCLK_DIV/2-1));
  assign rise_c        = en && (div_cnt == DIV_W'(BCLK_DIV-1));
  assign frame_start_c = fall_c && (slot == '0);

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S transmitter to the WM8731 DAC (codec slave): one-entry sample buffer,
// frame loader and MSB-first serialiser with the I2S one-bit delay.
module i2s_dac_tx #(
  parameter int unsigned BCLK_DIV = 4,
  parameter int unsigned SAMPLE_W = audio_pkg::SAMPLE_W,
  parameter int unsigned SLOTS    = audio_pkg::SLOTS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_done,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                aud_bclk,
  output logic                aud_daclrck,
  output logic                aud_dacdat,
  output logic                frame_tick,
  output logic [15:0]         underflow_cnt
);
  import audio_pkg::tx_state_e, audio_pkg::IDLE, audio_pkg::PRIME, audio_pkg::RUN;
  import audio_pkg::I2S_DELAY;

  localparam int unsigned SLOT_W = $clog2(2*SLOTS);

  tx_state_e state_q, state_d;
  logic      buf_full_q, buf_full_d, primed_q, primed_d;
  logic [SAMPLE_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic [SAMPLE_W-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic      bclk_d, lrck_d, dat_d, tick_d, ready_d;
  logic [15:0] ucnt_d;

  logic              clk_en_c, fall_c, rise_c, frame_start_c;
  logic [SLOT_W-1:0] slot, k_c;
  logic              right_c, data_slot_c;

  assign clk_en_c = cfg_done && (state_q != IDLE);

  i2s_clk_gen #(.BCLK_DIV(BCLK_DIV), .SLOTS(SLOTS)) u_clk_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (clk_en_c),
    .fall_c        (fall_c),
    .rise_c        (rise_c),
    .frame_start_c (frame_start_c),
    .slot          (slot)
  );

  assign right_c     = (slot >= SLOT_W'(SLOTS));
  assign k_c         = right_c ? slot - SLOT_W'(SLOTS) : slot;
  assign data_slot_c = (k_c >= SLOT_W'(I2S_DELAY)) && (k_c < SLOT_W'(SAMPLE_W + I2S_DELAY));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      buf_full_q    <= 1'b0;
      primed_q      <= 1'b0;
      buf_l_q       <= '0;
      buf_r_q       <= '0;
      sh_l_q        <= '0;
      sh_r_q        <= '0;
      s_ready       <= 1'b0;
      aud_bclk      <= 1'b0;
      aud_daclrck   <= 1'b0;
      aud_dacdat    <= 1'b0;
      frame_tick    <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      state_q       <= state_d;
      buf_full_q    <= buf_full_d;
      primed_q      <= primed_d;
      buf_l_q       <= buf_l_d;
      buf_r_q       <= buf_r_d;
      sh_l_q        <= sh_l_d;
      sh_r_q        <= sh_r_d;
      s_ready       <= ready_d;
      aud_bclk      <= bclk_d;
      aud_daclrck   <= lrck_d;
      aud_dacdat    <= dat_d;
      frame_tick    <= tick_d;
      underflow_cnt <= ucnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    buf_full_d = buf_full_q;
    primed_d   = primed_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    sh_l_d     = sh_l_q;
    sh_r_d     = sh_r_q;
    bclk_d     = aud_bclk;
    lrck_d     = aud_daclrck;
    dat_d      = aud_dacdat;
    tick_d     = 1'b0;
    ucnt_d     = underflow_cnt;

    case (state_q)
      IDLE: begin
        buf_full_d = 1'b0;
        primed_d   = 1'b0;
        bclk_d     = 1'b0;
        lrck_d     = 1'b0;
        dat_d      = 1'b0;
        if (cfg_done) state_d = PRIME;
      end
      default: begin
        if (!cfg_done) begin
          // abort: flush the buffer and park the bus low, keep the count
          state_d    = IDLE;
          buf_full_d = 1'b0;
          primed_d   = 1'b0;
          bclk_d     = 1'b0;
          lrck_d     = 1'b0;
          dat_d      = 1'b0;
        end else begin
          if (s_valid && s_ready) begin
            buf_full_d = 1'b1;
            buf_l_d    = s_left;
            buf_r_d    = s_right;
          end
          if (rise_c) bclk_d = 1'b1;
          if (fall_c) bclk_d = 1'b0;

          if (frame_start_c) begin
            tick_d = 1'b1;
            lrck_d = 1'b0;
            dat_d  = 1'b0;
            if (state_q == PRIME && !primed_q) begin
              sh_l_d   = '0;
              sh_r_d   = '0;
              primed_d = 1'b1;
            end else begin
              if (buf_full_q) begin
                sh_l_d     = buf_l_q;
                sh_r_d     = buf_r_q;
                buf_full_d = 1'b0;
              end else begin
                sh_l_d = '0;
                sh_r_d = '0;
                if (state_q == RUN && underflow_cnt != '1)
                  ucnt_d = underflow_cnt + 16'd1;
              end
              state_d = RUN;
            end
          end else if (fall_c) begin
            if (slot == SLOT_W'(SLOTS)) lrck_d = 1'b1;
            dat_d = 1'b0;
            if (data_slot_c) begin
              if (right_c) begin
                dat_d  = sh_r_q[SAMPLE_W-1];
                sh_r_d = {sh_r_q[SAMPLE_W-2:0], 1'b0};
              end else begin
                dat_d  = sh_l_q[SAMPLE_W-1];
                sh_l_d = {sh_l_q[SAMPLE_W-2:0], 1'b0};
              end
            end
          end
        end
      end
    endcase

    ready_d = (state_d != IDLE) && !buf_full_d;
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: decodes the I2S stream on rising BCLK and
// checks framing, sample content, buffering, underflow counting and abort.
module tb_i2s_dac_tx;

  logic        clk = 1'b0;
  logic        rst_n, cfg_done, s_valid;
  logic        s_ready;
  logic [23:0] s_left, s_right;
  logic        aud_bclk, aud_daclrck, aud_dacdat, frame_tick;
  logic [15:0] underflow_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  i2s_dac_tx #(.BCLK_DIV(4), .SAMPLE_W(24), .SLOTS(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_done      (cfg_done),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_left        (s_left),
    .s_right       (s_right),
    .aud_bclk      (aud_bclk),
    .aud_daclrck   (aud_daclrck),
    .aud_dacdat    (aud_dacdat),
    .frame_tick    (frame_tick),
    .underflow_cnt (underflow_cnt)
  );

  // stream decoder
  logic        prev_bclk = 1'b0, last_lr = 1'b1, prev_lr = 1'b0;
  int          since_rise = 0, bclk_per = 0, k = 0;
  int          lr_run = 0, lr_low_len = 0, lr_high_len = 0;
  logic [31:0] lbits = '0, rbits = '0;
  logic [23:0] cap_l[$], cap_r[$];
  logic        cap_pad[$];

  function automatic logic [23:0] dec(input logic [31:0] b);
    logic [23:0] w;
    for (int i = 1; i <= 24; i++) w[24-i] = b[i];
    return w;
  endfunction

  function automatic logic pad_nz(input logic [31:0] b);
    return b[0] | (|b[31:25]);
  endfunction

  always @(negedge clk) begin
    if (!cfg_done) begin
      last_lr = 1'b1;
      k = 0;
    end
    since_rise++;
    if (aud_bclk && !prev_bclk) begin
      bclk_per   = since_rise;
      since_rise = 0;
      if (aud_daclrck != last_lr) k = 0;
      else k++;
      last_lr = aud_daclrck;
      if (k < 32) begin
        if (aud_daclrck) rbits[k] = aud_dacdat;
        else lbits[k] = aud_dacdat;
      end
      if (aud_daclrck && k == 31) begin
        cap_l.push_back(dec(lbits));
        cap_r.push_back(dec(rbits));
        cap_pad.push_back(pad_nz(lbits) | pad_nz(rbits));
      end
    end
    prev_bclk = aud_bclk;
    if (aud_daclrck == prev_lr) lr_run++;
    else begin
      if (prev_lr) lr_high_len = lr_run;
      else lr_low_len = lr_run;
      lr_run = 1;
    end
    prev_lr = aud_daclrck;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(input string tag);
    int seen = 0;
    for (int i = 0; i < 400 && seen == 0; i++) begin
      @(negedge clk);
      if (frame_tick) seen = 1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  // called at a negedge; returns #1 after the accepting posedge
  task automatic send(input logic [23:0] l, input logic [23:0] r);
    int ok = 0;
    s_left  = l;
    s_right = r;
    s_valid = 1'b1;
    for (int i = 0; i < 600 && ok == 0; i++) begin
      if (s_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
      end else begin
        @(negedge clk);
      end
    end
    s_valid = 1'b0;
    chk("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic chk_frames(input string tag, input int n,
                            input logic [23:0] el[8], input logic [23:0] er[8]);
    chk({tag, "_count"}, 32'(cap_l.size()), 32'(n));
    if (cap_l.size() >= n) begin
      for (int i = 0; i < n; i++) begin
        chk($sformatf("%s_f%0d_left", tag, i), 32'(cap_l[i]), 32'(el[i]));
        chk($sformatf("%s_f%0d_right", tag, i), 32'(cap_r[i]), 32'(er[i]));
        chk($sformatf("%s_f%0d_pad", tag, i), 32'(cap_pad[i]), 32'd0);
      end
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  acc;
    logic [23:0] el[8];
    logic [23:0] er[8];

    rst_n = 1'b0; cfg_done = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
    wait_clk(3);
    chk("rst_bclk",  32'(aud_bclk),      32'd0);
    chk("rst_lrck",  32'(aud_daclrck),   32'd0);
    chk("rst_dat",   32'(aud_dacdat),    32'd0);
    chk("rst_ready", 32'(s_ready),       32'd0);
    chk("rst_tick",  32'(frame_tick),    32'd0);
    chk("rst_ucnt",  32'(underflow_cnt), 32'd0);
    rst_n = 1'b1;

    acc = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      acc |= {aud_bclk, aud_daclrck, aud_dacdat, s_ready, frame_tick};
    end
    chk("idle_quiet", 32'(acc), 32'd0);
    chk("idle_ucnt", 32'(underflow_cnt), 32'd0);

    cfg_done = 1'b1;
    wait_tick("tick_prime");
    chk("prime_lrck", 32'(aud_daclrck), 32'd0);
    chk("prime_ready", 32'(s_ready), 32'd1);
    wait_tick("tick_run");
    chk("run_ucnt0", 32'(underflow_cnt), 32'd0);

    send(24'hA5A5A5, 24'h123456);
    chk("ready_full", 32'(s_ready), 32'd0);
    wait_tick("tick_load1");
    chk("ready_return", 32'(s_ready), 32'd1);
    chk("ucnt_loaded", 32'(underflow_cnt), 32'd0);
    wait_clk(3);
    chk("slot0_dat", 32'(aud_dacdat), 32'd0);
    wait_clk(1);
    chk("msb_slot1", 32'(aud_dacdat), 32'd1);
    chk("bclk_period", 32'(bclk_per), 32'd4);

    send(24'h800000, 24'h7FFFFF);
    wait_tick("tick_load2");
    wait_tick("tick_mute1");
    wait_tick("tick_mute2");
    wait_tick("tick_mute3");
    chk("ucnt_3", 32'(underflow_cnt), 32'd3);
    wait_tick("tick_mute4");
    chk("lrck_low_len", 32'(lr_low_len), 32'd128);
    chk("lrck_high_len", 32'(lr_high_len), 32'd128);

    el = '{24'h0, 24'h0, 24'hA5A5A5, 24'h800000, 24'h0, 24'h0, 24'h0, 24'h0};
    er = '{24'h0, 24'h0, 24'h123456, 24'h7FFFFF, 24'h0, 24'h0, 24'h0, 24'h0};
    chk_frames("run", 7, el, er);

    // preload the counter near full scale instead of 70000 real frames
    force dut.underflow_cnt = 16'hFFFD;
    @(negedge clk);
    release dut.underflow_cnt;
    wait_tick("tick_sat1");
    wait_tick("tick_sat2");
    chk("ucnt_sat", 32'(underflow_cnt), 32'h0000FFFF);
    wait_tick("tick_sat3");
    chk("ucnt_hold", 32'(underflow_cnt), 32'h0000FFFF);

    send(24'h000000, 24'h7FFFFF);
    wait_tick("tick_drop_load");
    send(24'hFFFFFF, 24'hFFFFFF);
    wait_clk(168);
    chk("predrop_dat", 32'(aud_dacdat), 32'd1);
    chk("predrop_lrck", 32'(aud_daclrck), 32'd1);
    chk("predrop_ready", 32'(s_ready), 32'd0);

    cfg_done = 1'b0;
    wait_clk(1);
    chk("drop_bclk",  32'(aud_bclk),      32'd0);
    chk("drop_lrck",  32'(aud_daclrck),   32'd0);
    chk("drop_dat",   32'(aud_dacdat),    32'd0);
    chk("drop_ready", 32'(s_ready),       32'd0);
    chk("drop_tick",  32'(frame_tick),    32'd0);
    chk("drop_ucnt",  32'(underflow_cnt), 32'h0000FFFF);
    wait_clk(20);
    chk("idle2_bclk", 32'(aud_bclk), 32'd0);

    cap_l.delete();
    cap_r.delete();
    cap_pad.delete();
    cfg_done = 1'b1;
    wait_tick("re_prime");
    chk("re_ready", 32'(s_ready), 32'd1);
    wait_tick("re_run");
    send(24'h5A5A5A, 24'h0F0F0F);
    wait_tick("re_load");
    wait_tick("re_next");
    el = '{24'h0, 24'h0, 24'h5A5A5A, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
    er = '{24'h0, 24'h0, 24'h0F0F0F, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
    chk_frames("restart", 3, el, er);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
